// File: rtl/mc_controller.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode and
// per-class execute/writeback steps, with a sticky trap state for illegal opcodes.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       pc_en,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADR  = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_EXECUTE = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BEQ     = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_ADDIWB  = 4'd11;
  localparam logic [3:0] S_JUMP    = 4'd12;
  localparam logic [3:0] S_ERR     = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  function automatic logic funct_legal(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
           (f == F_OR)  || (f == F_SLT);
  endfunction

  function automatic logic [2:0] alu_decode(input logic [5:0] f);
    case (f)
      F_SUB:   return 3'b110;
      F_AND:   return 3'b000;
      F_OR:    return 3'b001;
      F_SLT:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  logic [3:0] state_q, state_d;
  logic [5:0] funct_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // funct is captured in DECODE so EXECUTE is immune to later IR changes
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) funct_q <= funct;
  end

  always_comb begin
    state_d = S_ERR;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_legal(funct) ? S_EXECUTE : S_ERR;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ERR;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:   state_d = S_ERR;
    endcase
  end

  always_comb begin
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = 3'b010;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = alu_decode(funct_q);
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = 1'b1;
        alu_control = 3'b110;
        pc_src      = 2'b01;
        branch      = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: ;
    endcase
  end

  assign pc_en   = pc_write | (branch & zero);
  assign state   = state_q;
  assign illegal = (state_q == S_ERR);

endmodule
